// File: rtl/exc_pkg.sv
// Shared types and constants for the fetch-path exception sequencer.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HANDLER = 2'd1,
    HALT    = 2'd2
  } exc_state_t;

  localparam logic [3:0] ESR_NONE    = 4'h0;
  localparam logic [3:0] ESR_ILLEGAL = 4'h1;
  localparam logic [3:0] ESR_IRQ     = 4'h2;
  localparam logic [3:0] ESR_DOUBLE  = 4'h3;

  // Handler image lives at ROM word 53.
  localparam logic [63:0] EXC_VECTOR_DEFAULT = 64'hD4;

endpackage

// File: rtl/exc_if.sv
// Decode-side requests and fetch-side steering signals of the exception sequencer.
interface exc_if #(
  parameter int unsigned N = 64
);
  logic         stall_d;
  logic [N-1:0] pc_d;
  logic         illegal_d;
  logic         ext_irq;
  logic         eret_d;
  logic         pc_redirect;
  logic [N-1:0] pc_target;
  logic         flush_fd;
  logic         flush_de;
  logic [N-1:0] elr;
  logic [3:0]   esr;
  logic         in_handler;
  logic         halted;

  modport master (
    output stall_d, pc_d, illegal_d, ext_irq, eret_d,
    input  pc_redirect, pc_target, flush_fd, flush_de, elr, esr, in_handler, halted
  );

  modport slave (
    input  stall_d, pc_d, illegal_d, ext_irq, eret_d,
    output pc_redirect, pc_target, flush_fd, flush_de, elr, esr, in_handler, halted
  );
endinterface

// File: rtl/exc_prio.sv
// Priority encoder: picks which decode event (if any) the sequencer acts on.
module exc_prio
  import exc_pkg::*;
(
  input  exc_state_t state,
  input  logic       illegal_d,
  input  logic       ext_irq,
  input  logic       eret_d,
  output logic       take,
  output logic [3:0] cause
);

  // In HANDLER, take with ESR_NONE means an ERET return; ext_irq is masked there.
  always_comb begin
    take  = 1'b0;
    cause = ESR_NONE;
    unique case (state)
      IDLE: begin
        if (illegal_d || eret_d) begin
          take  = 1'b1;
          cause = ESR_ILLEGAL;
        end else if (ext_irq) begin
          take  = 1'b1;
          cause = ESR_IRQ;
        end
      end
      HANDLER: begin
        if (illegal_d) begin
          take  = 1'b1;
          cause = ESR_DOUBLE;
        end else if (eret_d) begin
          take  = 1'b1;
          cause = ESR_NONE;
        end
      end
      default: begin
        take  = 1'b0;
        cause = ESR_NONE;
      end
    endcase
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: steers PC to the handler, saves ELR/ESR, flushes front end, handles ERET.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned  N          = 64,
  parameter logic [N-1:0] EXC_VECTOR = N'(EXC_VECTOR_DEFAULT)
) (
  input logic  clk,
  input logic  reset,
  exc_if.slave bus
);

  exc_state_t   state_q, state_nx;
  logic [N-1:0] elr_q, elr_nx;
  logic [3:0]   esr_q, esr_nx;
  logic         take;
  logic [3:0]   cause;
  logic         ev;

  exc_prio u_prio (
    .state     (state_q),
    .illegal_d (bus.illegal_d),
    .ext_irq   (bus.ext_irq),
    .eret_d    (bus.eret_d),
    .take      (take),
    .cause     (cause)
  );

  // Mealy outputs are also gated by reset so they drop while reset is held low.
  assign ev = reset && !bus.stall_d;

  always_comb begin
    state_nx        = state_q;
    elr_nx          = elr_q;
    esr_nx          = esr_q;
    bus.pc_redirect = 1'b0;
    bus.pc_target   = '0;
    bus.flush_fd    = 1'b0;
    bus.flush_de    = 1'b0;
    if (ev) begin
      unique case (state_q)
        IDLE: begin
          if (take) begin
            bus.pc_redirect = 1'b1;
            bus.pc_target   = EXC_VECTOR;
            bus.flush_fd    = 1'b1;
            bus.flush_de    = 1'b1;
            elr_nx          = bus.pc_d;
            esr_nx          = cause;
            state_nx        = HANDLER;
          end
        end
        HANDLER: begin
          if (take && cause == ESR_DOUBLE) begin
            bus.flush_fd = 1'b1;
            bus.flush_de = 1'b1;
            esr_nx       = ESR_DOUBLE;
            state_nx     = HALT;
          end else if (take) begin
            bus.pc_redirect = 1'b1;
            bus.pc_target   = elr_q;
            bus.flush_fd    = 1'b1;
            bus.flush_de    = 1'b1;
            state_nx        = IDLE;
          end
        end
        HALT: begin
          bus.flush_fd = 1'b1;
          bus.flush_de = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      elr_q   <= '0;
      esr_q   <= ESR_NONE;
    end else begin
      state_q <= state_nx;
      elr_q   <= elr_nx;
      esr_q   <= esr_nx;
    end
  end

  assign bus.elr        = elr_q;
  assign bus.esr        = esr_q;
  assign bus.in_handler = (state_q == HANDLER);
  assign bus.halted     = (state_q == HALT);

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  exc_if #(.N(64)) bus ();

  exc_ctrl #(.N(64), .EXC_VECTOR(64'hD4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_comb(input string tag, input logic redir, input logic [63:0] tgt,
                          input logic flush);
    chk({tag, ".redirect"}, {63'd0, bus.pc_redirect}, {63'd0, redir});
    chk({tag, ".target"},   bus.pc_target, tgt);
    chk({tag, ".flush_fd"}, {63'd0, bus.flush_fd}, {63'd0, flush});
    chk({tag, ".flush_de"}, {63'd0, bus.flush_de}, {63'd0, flush});
  endtask

  task automatic chk_reg(input string tag, input logic [63:0] elr, input logic [3:0] esr,
                         input logic inh, input logic hlt);
    chk({tag, ".elr"},        bus.elr, elr);
    chk({tag, ".esr"},        {60'd0, bus.esr}, {60'd0, esr});
    chk({tag, ".in_handler"}, {63'd0, bus.in_handler}, {63'd0, inh});
    chk({tag, ".halted"},     {63'd0, bus.halted}, {63'd0, hlt});
  endtask

  task automatic idle_inputs();
    bus.stall_d   = 1'b0;
    bus.illegal_d = 1'b0;
    bus.ext_irq   = 1'b0;
    bus.eret_d    = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    bus.pc_d    = 64'h0;
    idle_inputs();

    // Reset held low
    step();
    step();
    chk_comb("rst_low", 1'b0, 64'h0, 1'b0);
    chk_reg("rst_low", 64'h0, 4'h0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    chk_comb("rst_rel", 1'b0, 64'h0, 1'b0);
    chk_reg("rst_rel", 64'h0, 4'h0, 1'b0, 1'b0);

    // Illegal opcode in IDLE
    bus.illegal_d = 1'b1;
    bus.pc_d      = 64'h10;
    #1;
    chk_comb("ill_take", 1'b1, 64'hD4, 1'b1);
    step();
    bus.illegal_d = 1'b0;
    bus.pc_d      = 64'hD4;
    #1;
    chk_reg("ill_entered", 64'h10, 4'h1, 1'b1, 1'b0);
    chk_comb("ill_quiet", 1'b0, 64'h0, 1'b0);

    // ERET back to the saved PC
    bus.eret_d = 1'b1;
    bus.pc_d   = 64'hD8;
    #1;
    chk_comb("eret1", 1'b1, 64'h10, 1'b1);
    step();
    bus.eret_d = 1'b0;
    bus.pc_d   = 64'h10;
    #1;
    chk_reg("eret1_done", 64'h10, 4'h1, 1'b0, 1'b0);

    // IRQ held off by a two-cycle stall
    bus.ext_irq = 1'b1;
    bus.pc_d    = 64'h8;
    bus.stall_d = 1'b1;
    #1;
    chk_comb("irq_stall0", 1'b0, 64'h0, 1'b0);
    step();
    chk_comb("irq_stall1", 1'b0, 64'h0, 1'b0);
    chk_reg("irq_stall1", 64'h10, 4'h1, 1'b0, 1'b0);
    step();
    bus.stall_d = 1'b0;
    #1;
    chk_comb("irq_take", 1'b1, 64'hD4, 1'b1);
    step();
    bus.pc_d = 64'hD8;
    #1;
    chk_reg("irq_entered", 64'h8, 4'h2, 1'b1, 1'b0);
    chk_comb("irq_masked", 1'b0, 64'h0, 1'b0);

    // ERET with IRQ still high, then IRQ retaken
    step();
    bus.eret_d = 1'b1;
    bus.pc_d   = 64'hDC;
    #1;
    chk_comb("eret2", 1'b1, 64'h8, 1'b1);
    step();
    bus.eret_d = 1'b0;
    bus.pc_d   = 64'h20;
    #1;
    chk_reg("eret2_done", 64'h8, 4'h2, 1'b0, 1'b0);
    chk_comb("irq_retake", 1'b1, 64'hD4, 1'b1);
    step();
    bus.ext_irq = 1'b0;
    bus.pc_d    = 64'hD4;
    #1;
    chk_reg("irq_reentered", 64'h20, 4'h2, 1'b1, 1'b0);

    // Double fault
    bus.illegal_d = 1'b1;
    bus.pc_d      = 64'hE0;
    #1;
    chk_comb("dfault", 1'b0, 64'h0, 1'b1);
    step();
    bus.illegal_d = 1'b0;
    bus.eret_d    = 1'b1;
    bus.ext_irq   = 1'b1;
    #1;
    chk_reg("halt", 64'h20, 4'h3, 1'b0, 1'b1);
    chk_comb("halt", 1'b0, 64'h0, 1'b1);
    step();
    step();
    chk_reg("halt_hold", 64'h20, 4'h3, 1'b0, 1'b1);
    chk_comb("halt_hold", 1'b0, 64'h0, 1'b1);

    // Reset out of HALT, re-enter handler, async reset mid-cycle
    idle_inputs();
    reset = 1'b0;
    #1;
    chk_reg("halt_rst", 64'h0, 4'h0, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    step();
    bus.illegal_d = 1'b1;
    bus.pc_d      = 64'h30;
    step();
    bus.illegal_d = 1'b0;
    bus.eret_d    = 1'b1;
    #1;
    chk_reg("pre_async", 64'h30, 4'h1, 1'b1, 1'b0);
    chk_comb("pre_async", 1'b1, 64'h30, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk_comb("async_rst", 1'b0, 64'h0, 1'b0);
    chk_reg("async_rst", 64'h0, 4'h0, 1'b0, 1'b0);
    idle_inputs();
    step();
    reset = 1'b1;
    step();
    chk_reg("post_rst", 64'h0, 4'h0, 1'b0, 1'b0);
    chk_comb("post_rst", 1'b0, 64'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception sequencer for the fetch path feeding the 128-word instruction ROM (7-bit word address, 32-bit instructions).
- Detects exception requests at decode, then steers the PC to the exception vector. The handler image sits at ROM word 53, byte address 0xD4.
- Saves return PC (ELR) and cause (ESR), flushes the front-end pipeline registers, and handles ERET return.
- Sits beside the fetch/decode stages, driving the PC mux select and the flush inputs of IF/ID and ID/EX.

Parameters:
- N, 64, PC/ELR width in bits.
- EXC_VECTOR, 64'hD4, byte address of the handler entry.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; asynchronous and active-low, asserted when reset==0.
- stall_d  in  1  decode stage stalled; no event is accepted this cycle.
- pc_d  in  N  PC of the instruction currently in decode.
- illegal_d  in  1  decode flags an undefined opcode.
- ext_irq  in  1  level-sensitive external interrupt.
- eret_d  in  1  decode holds an ERET instruction.
- pc_redirect  out  1  load PC from pc_target at the next edge.
- pc_target  out  N  redirect destination.
- flush_fd  out  1  clear IF/ID at the next edge.
- flush_de  out  1  clear ID/EX at the next edge.
- elr  out  N  saved return PC.
- esr  out  4  saved cause code.
- in_handler  out  1  handler currently executing.
- halted  out  1  double fault; processor frozen.

Behaviour:
- States: IDLE, HANDLER, HALT. State, elr and esr are registers; redirect and flush outputs are combinational (Mealy) from state and inputs.
- Reset (reset==0, asynchronous): state=IDLE, elr=0, esr=ESR_NONE(4'h0). All outputs are 0 while reset is low and on the first cycle after release.
- Event enable: ev = !stall_d. When stall_d=1, every output except elr, esr, in_handler and halted is 0, and no state change occurs.
- IDLE, priority illegal_d > ext_irq (eret_d in IDLE is treated as illegal):
  - Any request with ev=1: assert pc_redirect=1, pc_target=EXC_VECTOR, flush_fd=flush_de=1 in the same cycle.
  - At the next edge: elr<=pc_d, esr<=cause, state<=HANDLER.
  - Cause codes: ESR_ILLEGAL=4'h1 (also undefined ERET), ESR_IRQ=4'h2.
  - The decode instruction is squashed; ELR points at it, so the IRQ return re-executes it.
- HANDLER:
  - ext_irq is masked. It stays pending because it is level-sensitive, and is taken in the first IDLE cycle after return where it is still high.
  - eret_d with ev=1: pc_redirect=1, pc_target=elr, flush_fd=flush_de=1; next edge state<=IDLE. elr and esr are held, not cleared.
  - illegal_d with ev=1 is a double fault: no redirect; flush_fd=flush_de=1; next edge state<=HALT, esr<=ESR_DOUBLE(4'h3), elr unchanged.
  - Simultaneous eret_d and illegal_d is impossible (single decode slot). If seen, illegal_d wins.
- HALT:
  - halted=1, flush_fd=flush_de=1 every cycle, pc_redirect=0.
  - Exits only via reset.
- in_handler = (state==HANDLER).
- Reset asserted mid-handler returns to IDLE immediately, with elr and esr zeroed.
- pc_target=0 whenever pc_redirect=0.
- Widths: elr is a full N bits. The ROM word address is formed downstream as pc[8:2]; this block never truncates.

Decomposition:
- Package exc_pkg holds:
  - typedef enum logic [1:0] exc_state_t {IDLE, HANDLER, HALT};
  - constants ESR_NONE, ESR_ILLEGAL, ESR_IRQ, ESR_DOUBLE (logic [3:0]);
  - default EXC_VECTOR.
- One natural sub-module, exc_prio: combinational priority encoder from illegal_d, ext_irq, eret_d and state to {take, cause}. Everything else stays in exc_ctrl.

Test Plan:
- Reset then illegal_d=1, pc_d=0x10, ev=1 → same cycle pc_redirect=1, pc_target=0xD4, flush_fd=flush_de=1. Next cycle elr=0x10, esr=1, in_handler=1.
- Handler entered, eret_d=1 → pc_redirect=1, pc_target=0x10, flushes=1. Next cycle in_handler=0, elr still 0x10.
- ext_irq=1 at pc_d=0x8, stall_d=1 for 2 cycles then 0 → no redirect during the stall. Redirect on the first unstalled cycle, with elr=0x8 and esr=2.
- ext_irq held high through the handler, then ERET at pc_d=0xDC → ERET redirect to elr. The following unstalled cycle takes the IRQ again (esr=2, elr=the new pc_d).
- illegal_d in HANDLER → no redirect, flushes=1. Next cycle halted=1, esr=3, elr unchanged. Further inputs are ignored until reset.
- reset pulled low asynchronously mid-cycle while in HANDLER → outputs drop to 0 before the next clk edge, with elr=0, esr=0 and state IDLE.
